// File: rtl/uart_frame_loader.sv
// rtl/uart_frame_loader.sv - UART framed program image loader into SRAM with core reset control
module uart_frame_loader #(
    parameter int          ADDR_WIDTH     = 13,
    parameter logic [7:0]  MAGIC          = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 5000000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_byte_i,
    output logic                  mem_csb_o,
    output logic                  mem_web_o,
    output logic [3:0]            mem_wmask_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_data_o,
    output logic                  core_reset_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM
    } state_t;

    localparam int         TW      = $clog2(TIMEOUT_CYCLES + 1);
    // Largest accepted word count: the whole SRAM, never more.
    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [TW-1:0]         idle_cnt_q;
    logic [7:0]            len_lo_q;
    logic [7:0]            sum_q;
    logic [15:0]           words_left_q;
    logic [ADDR_WIDTH-1:0] next_addr_q;
    logic [1:0]            byte_idx_q;
    logic [23:0]           word_q;
    logic                  wr_q;
    logic                  done_q;
    logic                  err_q;
    logic                  core_rel_q;
    logic                  started_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_data_q;

    logic [15:0]           len_rx;
    logic                  timeout;
    logic                  abort;
    logic                  magic_ok;
    logic                  csum_ok;
    logic                  word_done;

    assign len_rx  = {rx_byte_i, len_lo_q};
    // A byte arriving in the would-be timeout cycle keeps the frame alive.
    assign timeout = (state_q != S_IDLE) && !rx_valid_i &&
                     (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // State register; reset drops any frame in flight immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame decode: next state plus the per-byte event strobes.
    always_comb begin
        state_d   = state_q;
        abort     = 1'b0;
        magic_ok  = 1'b0;
        csum_ok   = 1'b0;
        word_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_valid_i && (rx_byte_i == MAGIC)) begin
                    magic_ok = 1'b1;
                    state_d  = S_LEN0;
                end
            end
            S_LEN0: begin
                if (rx_valid_i) begin
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (rx_valid_i) begin
                    if ({1'b0, len_rx} > MAX_LEN) begin
                        abort = 1'b1;
                    end else if (len_rx == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid_i && (byte_idx_q == 2'd3)) begin
                    word_done = 1'b1;
                    if (words_left_q == 16'd1) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (rx_valid_i) begin
                    if (rx_byte_i == sum_q) begin
                        csum_ok = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (timeout) begin
            abort = 1'b1;
        end
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // Datapath: word assembly, checksum, counters, write strobe and status flags.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idle_cnt_q   <= '0;
            len_lo_q     <= '0;
            sum_q        <= '0;
            words_left_q <= '0;
            next_addr_q  <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            wr_q         <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rel_q   <= 1'b0;
            started_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            started_q <= 1'b1;
            wr_q      <= word_done;
            done_q    <= csum_ok;

            if ((state_q == S_IDLE) || rx_valid_i) begin
                idle_cnt_q <= '0;
            end else begin
                idle_cnt_q <= idle_cnt_q + TW'(1);
            end

            if (magic_ok) begin
                err_q <= 1'b0;
            end else if (abort) begin
                err_q <= 1'b1;
            end

            // Core is released once out of reset, and afterwards only by a good frame.
            if (magic_ok) begin
                core_rel_q <= 1'b0;
            end else if (csum_ok || !started_q) begin
                core_rel_q <= 1'b1;
            end

            if (magic_ok) begin
                sum_q <= '0;
            end else if (rx_valid_i && (state_q inside {S_LEN0, S_LEN1, S_DATA})) begin
                sum_q <= sum_q + rx_byte_i;
            end

            if ((state_q == S_LEN0) && rx_valid_i) begin
                len_lo_q <= rx_byte_i;
            end

            if ((state_q == S_LEN1) && rx_valid_i) begin
                words_left_q <= len_rx;
            end else if (word_done) begin
                words_left_q <= words_left_q - 16'd1;
            end

            if (magic_ok) begin
                next_addr_q <= '0;
                byte_idx_q  <= '0;
            end else begin
                if (word_done) begin
                    next_addr_q <= next_addr_q + ADDR_WIDTH'(1);
                end
                if ((state_q == S_DATA) && rx_valid_i) begin
                    byte_idx_q <= byte_idx_q + 2'd1;
                end
            end

            // Little-endian: earlier bytes shift down toward bit 0.
            if ((state_q == S_DATA) && rx_valid_i) begin
                word_q <= {rx_byte_i, word_q[23:8]};
            end

            if (word_done) begin
                mem_addr_q <= next_addr_q;
                mem_data_q <= {rx_byte_i, word_q};
            end
        end
    end

    assign mem_csb_o    = ~wr_q;
    assign mem_web_o    = ~wr_q;
    assign mem_wmask_o  = {4{wr_q}};
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign core_reset_o = core_rel_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: doc/uart_frame_loader.md
# uart_frame_loader

Consumes the received-byte stream from the UART receiver, decodes a framed program image and writes it word by word into the data/instruction SRAM port. It holds the core in reset while a load is in progress and releases it only after a frame passes its checksum. It sits between the UART receive path and the SRAM/core reset in the FPGA top.

## Interface
- ADDR_WIDTH, 13: SRAM word-address width; the image may hold at most 2^ADDR_WIDTH words.
- MAGIC, 8'hA5: frame start byte.
- TIMEOUT_CYCLES, 5000000: maximum idle cycles allowed between bytes inside a frame.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  reset, asynchronous, active-high.
- rx_valid_i  in  1  one-cycle pulse when a received byte is present.
- rx_byte_i  in  8  received byte; valid only while rx_valid_i=1.
- mem_csb_o  out  1  SRAM chip select, active-low.
- mem_web_o  out  1  SRAM write enable, active-low.
- mem_wmask_o  out  4  byte mask; 4'b1111 during writes, 4'b0000 otherwise.
- mem_addr_o  out  ADDR_WIDTH  SRAM word address.
- mem_data_o  out  32  write data.
- core_reset_o  out  1  core reset, active-low; 0 holds the core.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse on successful load.
- err_o  out  1  sticky error flag.

## Operation
- Frame layout: MAGIC, LEN_LO, LEN_HI, then N=LEN 32-bit words (4 bytes each, little-endian), then CSUM.
- CSUM must equal the 8-bit sum, mod 256, of every byte after MAGIC (length bytes and payload).
- States and transitions:
  - IDLE: a byte equal to MAGIC moves to LEN0. Any other byte is ignored, with no output change.
  - LEN0 -> LEN1.
  - LEN1: if LEN > 2^ADDR_WIDTH, abort. If LEN=0, go to CSUM. Otherwise go to DATA.
  - DATA: collects bytes into a word. On each 4th byte it issues a write. After word N it goes to CSUM.
  - CSUM: on a match, go to IDLE with success. On a mismatch, abort.
- Words are written to addresses 0, 1, ... N-1. The address counter never wraps; oversize lengths are rejected in LEN1.
- Abort: set err_o=1, return to IDLE, keep core_reset_o=0. The partially written memory is left as is.
- Timeout: in LEN0, LEN1, DATA or CSUM, an idle counter increments every cycle without rx_valid_i and clears on each byte. Reaching TIMEOUT_CYCLES aborts. If a byte arrives in the same cycle as the timeout, the byte wins.
- err_o clears when the next MAGIC is accepted in IDLE. A reset also clears it.
- core_reset_o:
  - Goes to 1 in the first cycle after reset deasserts, if no frame is in progress.
  - Goes to 0 when MAGIC is accepted.
  - Returns to 1 only on a CSUM match; it stays 0 after an abort until the next good frame.
- Reset mid-frame: all state clears immediately. No further writes are issued.

## Timing
- Reset values: mem_csb_o=1, mem_web_o=1, mem_wmask_o=0, mem_addr_o=0, mem_data_o=0, core_reset_o=0, busy_o=0, done_o=0, err_o=0.
- MAGIC accepted at cycle t: busy_o=1 and core_reset_o=0 at t+1.
- Write: 4th byte of a word at cycle t. At t+1, mem_csb_o=0, mem_web_o=0 and mem_wmask_o=1111 for exactly one cycle, with mem_addr_o and mem_data_o valid. Address and data stay stable until the next write.
- A byte arriving during the write cycle is accepted normally. The minimum spacing between bytes is 1 cycle.
- CSUM match at cycle t: done_o=1 for one cycle, busy_o=0 and core_reset_o=1, all at t+1.
- Abort at cycle t: err_o=1 and busy_o=0 at t+1.

## Test plan
- Normal load: send A5 02 00 78 56 34 12 EF BE AD DE 4E. Expect writes addr0=0x12345678 and addr1=0xDEADBEEF, a done_o pulse, and core_reset_o=1 one cycle after 0x4E.
- Bad checksum: the same frame ending in 0x4F gives both writes, then err_o=1, core_reset_o=0 and no done_o. A following good frame clears err_o and releases the core.
- Empty image: A5 00 00 00 gives no writes, a done_o pulse and core_reset_o=1. Bytes 0x11 0x22 sent in IDLE before it cause no state change.
- Oversize length: A5 01 20 (LEN=0x2001 with ADDR_WIDTH=13) gives err_o=1 one cycle after 0x20, no writes, and core_reset_o=0.
- Timeout (TIMEOUT_CYCLES=100): send A5 01 00 78 56, then silence. Expect err_o=1 after 100 idle cycles and no write. A byte on cycle 99 prevents the abort.
- Reset mid-frame: assert reset_i after byte 3 of a word. All outputs return to their reset values asynchronously, and no write follows.
